// File: rtl/reorder_buffer.sv
// In-order retirement buffer: records renamed destinations in program order, marks
// completion from CDB broadcasts and retires at most one done entry per cycle from the head.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE     = 8,
  parameter int unsigned REG_ADDR_LEN = 5,
  parameter int unsigned TAG_W        = $clog2(ROB_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    dispatch_valid,
  input  logic [REG_ADDR_LEN-1:0] dispatch_arch_dest,
  input  logic [REG_ADDR_LEN-1:0] dispatch_phys_dest,
  output logic                    dispatch_ready,
  output logic [TAG_W-1:0]        dispatch_rob_tag,
  input  logic                    cdb_valid,
  input  logic [TAG_W-1:0]        cdb_rob_tag,
  output logic                    commit_flag,
  output logic [REG_ADDR_LEN-1:0] commit_phys_reg,
  output logic [REG_ADDR_LEN-1:0] commit_arch_reg,
  output logic [TAG_W:0]          rob_count,
  output logic                    rob_empty
);

  localparam logic [TAG_W:0] CountFull = (TAG_W + 1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0]     valid_q;
  logic [ROB_SIZE-1:0]     done_q;
  logic [REG_ADDR_LEN-1:0] arch_q [ROB_SIZE];
  logic [REG_ADDR_LEN-1:0] phys_q [ROB_SIZE];
  logic [TAG_W-1:0]        head_q;
  logic [TAG_W-1:0]        tail_q;
  logic [TAG_W:0]          count_q;

  logic do_dispatch;
  logic do_complete;
  logic do_retire;

  // No same-cycle bypass: a retire does not free a slot for a dispatch at the same edge.
  assign dispatch_ready   = (count_q != CountFull);
  assign dispatch_rob_tag = tail_q;
  assign rob_count        = count_q;
  assign rob_empty        = (count_q == '0);

  assign do_dispatch = dispatch_valid && dispatch_ready;
  assign do_complete = cdb_valid && valid_q[cdb_rob_tag];
  assign do_retire   = valid_q[head_q] && done_q[head_q];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q         <= '0;
      done_q          <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_flag     <= 1'b0;
      commit_phys_reg <= '0;
      commit_arch_reg <= '0;
    end else begin
      if (do_dispatch) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        arch_q[tail_q]  <= dispatch_arch_dest;
        phys_q[tail_q]  <= dispatch_phys_dest;
        tail_q          <= tail_q + 1'b1;
      end

      if (do_complete) begin
        done_q[cdb_rob_tag] <= 1'b1;
      end

      // Retire last so a repeat CDB to the retiring head cannot leave a stale done bit.
      if (do_retire) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + 1'b1;
        commit_flag     <= 1'b1;
        commit_phys_reg <= phys_q[head_q];
        commit_arch_reg <= arch_q[head_q];
      end else begin
        commit_flag <= 1'b0;
      end

      unique case ({do_dispatch, do_retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
